// File: rtl/qdec_pkg.sv
// Shared types and the phase-step classifier for the quadrature decoder.
// Phase encoding is {A,B}; the forward (up) order is 00->01->11->10->00.
package qdec_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } qdec_state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef struct packed {
        logic valid;
        logic dir;
        logic illegal;
    } qdec_dir_t;

    // dir is only meaningful when valid is set; 1 = up
    function automatic qdec_dir_t qdec_dir(input logic [1:0] p, input logic [1:0] s);
        qdec_dir_t r;
        r = '0;
        if (p != s) begin
            if ((p ^ s) == 2'b11) begin
                r.illegal = 1'b1;
            end else begin
                r.valid = 1'b1;
                r.dir   = ((p == PH_00) && (s == PH_01)) ||
                          ((p == PH_01) && (s == PH_11)) ||
                          ((p == PH_11) && (s == PH_10)) ||
                          ((p == PH_10) && (s == PH_00));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Per-phase synchronizer chain plus optional stability filter (QDEC_FILTER_EN).
// Latency: SYNC_STAGES cycles, plus FILTER_LEN with the filter; no backpressure.
// Backpressure: none, the output simply follows the (filtered) input level.
module qdec_sync_filter #(
    parameter int SYNC_STAGES = 2
`ifdef QDEC_FILTER_EN
    , parameter int FILTER_LEN = 4
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] r_cnt;
    logic          r_q;
    logic          w_in;

    assign w_in = r_sync[SYNC_STAGES-1];

    // r_cnt counts consecutive cycles the input has disagreed with r_q
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (w_in == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_q   <= w_in;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q = r_q;
`else
    assign q = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: count-enable pulse + direction, sticky error and saturating error count.
// Latency: pin edge to cnt_en is SYNC_STAGES+1 cycles (+FILTER_LEN when QDEC_FILTER_EN is defined).
// Backpressure: none; accepts one quarter-step per cycle, en=0 only suppresses pulses and errors.
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 err_clr,
    output logic                 cnt_en,
    output logic                 cnt_mode,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           phase
);
    import qdec_pkg::*;

`ifdef QDEC_FILTER_EN
    localparam int FILT_LAT = FILTER_LEN;
`else
    localparam int FILT_LAT = 0 * FILTER_LEN;
`endif
    // INIT spans the full input pipeline so phase holds a real sample before RUN compares
    localparam int INIT_LEN = SYNC_STAGES + 1 + FILT_LAT;
    localparam int ICW      = $clog2(INIT_LEN + 1);

    logic                 w_a;
    logic                 w_b;
    logic [1:0]           w_s;
    qdec_dir_t            w_dir;
    logic                 w_err_evt;

    qdec_state_t          r_state;
    logic [ICW-1:0]       r_init_cnt;
    logic [1:0]           r_phase;
    logic                 r_cnt_en;
    logic                 r_cnt_mode;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

`ifdef QDEC_FILTER_EN
    qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_a (
        .clk(clk), .rst(rst), .d_async(a_in), .q(w_a)
    );
    qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_b (
        .clk(clk), .rst(rst), .d_async(b_in), .q(w_b)
    );
`else
    qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk(clk), .rst(rst), .d_async(a_in), .q(w_a)
    );
    qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk(clk), .rst(rst), .d_async(b_in), .q(w_b)
    );
`endif

    assign w_s       = {w_a, w_b};
    assign w_dir     = qdec_dir(r_phase, w_s);
    assign w_err_evt = (r_state == RUN) && en && w_dir.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_phase    <= PH_00;
            r_cnt_en   <= 1'b0;
            r_cnt_mode <= 1'b1;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            // previous phase always tracks, so re-enabling cannot emit a stale step
            r_phase  <= w_s;
            r_cnt_en <= 1'b0;

            case (r_state)
                INIT: begin
                    if (r_init_cnt == ICW'(INIT_LEN - 1)) begin
                        r_state <= RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (en && w_dir.valid) begin
                        r_cnt_en   <= 1'b1;
                        r_cnt_mode <= w_dir.dir;
                    end
                end
                default: r_state <= INIT;
            endcase

            // a fresh error outranks a simultaneous clear
            if (w_err_evt) begin
                r_err <= 1'b1;
                if (err_clr) begin
                    r_err_cnt <= ERR_CNT_W'(1);
                end else if (!(&r_err_cnt)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (err_clr) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end
        end
    end

    assign cnt_en   = r_cnt_en;
    assign cnt_mode = r_cnt_mode;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign phase    = r_phase;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed, table-driven bench for quad_decoder; default parameters, filter-aware via QDEC_FILTER_EN.
module tb_quad_decoder;

    localparam int SYNC = 2;
`ifdef QDEC_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 0;
`endif
    localparam int LAT  = SYNC + 1 + FILT;
    localparam int STEP = (FILT == 0) ? 1 : FILT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       err_clr = 1'b0;
    logic       cnt_en;
    logic       cnt_mode;
    logic       err;
    logic [7:0] err_cnt;
    logic [1:0] phase;

    int total = 0;
    int bad   = 0;

    quad_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
        .cnt_en(cnt_en), .cnt_mode(cnt_mode), .err(err), .err_cnt(err_cnt), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       en;
        logic       clr;
        logic       qz;      // zero the counter model before this row
        logic       qchk;    // check the counter model after this row
        int         hold;
        int         pulses;
        logic       mode;
        logic [1:0] ph;
        logic       err;
        int         ecnt;
    } vec_t;

    vec_t       tbl[19];
    logic [7:0] q_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // apply inputs, hold n cycles, return pulses seen and fold them into the counter model
    task automatic drive(input logic a, input logic b, input int n, output int pulses);
        a_in   = a;
        b_in   = b;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (cnt_en === 1'b1) begin
                pulses++;
                if (cnt_mode) q_model = q_model + 8'd1;
                else          q_model = q_model - 8'd1;
            end
        end
    endtask

    initial begin
        int p;
        int n;
        q_model = 8'd0;

        //             a    b    en   clr  qz   qchk hold pul mode  ph     err  ecnt
        tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b10, 1'b0, 0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b00, 1'b0, 0};
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b01, 1'b0, 0};
        tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b11, 1'b0, 0};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b10, 1'b0, 0};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b00, 1'b0, 0};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,10, 1, 1'b0, 2'b10, 1'b0, 0};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b0, 2'b11, 1'b0, 0};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b0, 2'b01, 1'b0, 0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,10, 1, 1'b0, 2'b00, 1'b0, 0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,10, 0, 1'b0, 2'b01, 1'b0, 0};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,10, 0, 1'b0, 2'b11, 1'b0, 0};
        tbl[12] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,10, 0, 1'b0, 2'b11, 1'b0, 0};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b10, 1'b0, 0};
        tbl[14] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b00, 1'b0, 0};
        tbl[15] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,10, 1, 1'b1, 2'b01, 1'b0, 0};
        tbl[16] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,10, 0, 1'b1, 2'b10, 1'b1, 1};
        tbl[17] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 3, 0, 1'b1, 2'b10, 1'b0, 0};
        tbl[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,10, 0, 1'b1, 2'b01, 1'b0, 0};

        // reset with both phases high
        rst = 1'b1; a_in = 1'b1; b_in = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_cnt_mode", 32'(cnt_mode), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            tick();
            check("init_no_pulse", 32'(cnt_en), 32'd0);
            check("init_no_err", 32'(err), 32'd0);
        end
        check("init_phase", 32'(phase), 32'd3);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n += int'(cnt_en) + int'(err);
        end
        check("init_quiet", 32'(n), 32'd0);

        for (int i = 0; i < 19; i++) begin
            en      = tbl[i].en;
            err_clr = tbl[i].clr;
            if (tbl[i].qz) q_model = 8'd0;
            drive(tbl[i].a, tbl[i].b, tbl[i].hold, p);
            err_clr = 1'b0;
            check($sformatf("row%0d_pulses", i), 32'(p), 32'(tbl[i].pulses));
            check($sformatf("row%0d_mode", i), 32'(cnt_mode), 32'(tbl[i].mode));
            check($sformatf("row%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
            check($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].err));
            check($sformatf("row%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].ecnt));
            if (tbl[i].qchk) begin
                check($sformatf("row%0d_counter_q", i), 32'(q_model), 32'd252);
                check($sformatf("row%0d_tc_down", i), 32'(q_model == 8'd0), 32'd0);
            end
        end
        en = 1'b1;

        // edge-to-pulse latency and single-cycle pulse width (01 -> 11)
        a_in = 1'b1; b_in = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (cnt_en !== 1'b1 && n < 20);
        check("latency", 32'(n), 32'(LAT));
        tick();
        check("pulse_width", 32'(cnt_en), 32'd0);
        for (int k = 0; k < 10; k++) tick();

        // one error, then an error landing on the same cycle as err_clr
        drive(1'b1, 1'b0, 10, p);
        drive(1'b0, 1'b1, 10, p);
        check("err_single", 32'(err_cnt), 32'd1);
        a_in = 1'b1; b_in = 1'b0;
        for (int k = 0; k < LAT - 1; k++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_race_err", 32'(err), 32'd1);
        check("clr_race_cnt", 32'(err_cnt), 32'd1);

        // 300 illegal jumps saturate the count
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b1, STEP, p);
            else            drive(1'b1, 1'b0, STEP, p);
        end
        for (int k = 0; k < 10; k++) tick();
        check("sat_err", 32'(err), 32'd1);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);

        // back-to-back forward steps at the fastest rate the input path passes
        n = 0;
        drive(1'b0, 1'b0, STEP, p); n += p;
        drive(1'b0, 1'b1, STEP, p); n += p;
        drive(1'b1, 1'b1, STEP, p); n += p;
        drive(1'b1, 1'b0, STEP, p); n += p;
        drive(1'b1, 1'b0, 12, p);   n += p;
        check("b2b_pulses", 32'(n), 32'd4);
        check("b2b_mode", 32'(cnt_mode), 32'd1);

`ifdef QDEC_FILTER_EN
        // 3-cycle glitch on A is rejected; a 5-cycle level is accepted
        n = 0;
        drive(1'b0, 1'b0, 3, p);  n += p;
        drive(1'b1, 1'b0, 20, p); n += p;
        check("glitch_pulses", 32'(n), 32'd0);
        check("glitch_phase", 32'(phase), 32'd2);
        drive(1'b0, 1'b0, 5, p);  n = p;
        drive(1'b0, 1'b0, 15, p); n += p;
        check("level_pulses", 32'(n), 32'd1);
        check("level_phase", 32'(phase), 32'd0);
`endif

        // reset mid-operation after a down step and an error
        drive(1'b0, 1'b0, 10, p);
        drive(1'b1, 1'b0, 10, p);
        drive(1'b0, 1'b1, 10, p);
        check("pre_rst_mode", 32'(cnt_mode), 32'd0);
        check("pre_rst_err", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_mode", 32'(cnt_mode), 32'd1);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_phase", 32'(phase), 32'd0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            tick();
            n += int'(cnt_en) + int'(err);
        end
        check("post_rst_quiet", 32'(n), 32'd0);
        check("post_rst_phase", 32'(phase), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
